// File: rtl/inst_encoder.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : inst_encoder                                                 |
// | Purpose  : packs micro-op fields into MIPS32 words, PC-tagged, FIFO'd.  |
// |            Optional macro INST_ENC_ILLEGAL_CHECK_EN drops undefined ops |
// |            and pulses err_o instead of encoding them as NOP.            |
// | Revision : 1.0  initial release                                         |
// +-------------------------------------------------------------------------+
module inst_encoder #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [4:0]               op_i,
  input  logic [4:0]               rs_i,
  input  logic [4:0]               rt_i,
  input  logic [4:0]               rd_i,
  input  logic [4:0]               sa_i,
  input  logic [15:0]              imm_i,
  input  logic                     flush_i,
  input  logic [31:0]              flush_pc_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [31:0]              inst_o,
  output logic [31:0]              pc_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     err_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  localparam logic [4:0] C_OP_NOP  = 5'd0;
  localparam logic [4:0] C_OP_AND  = 5'd1;
  localparam logic [4:0] C_OP_OR   = 5'd2;
  localparam logic [4:0] C_OP_XOR  = 5'd3;
  localparam logic [4:0] C_OP_NOR  = 5'd4;
  localparam logic [4:0] C_OP_SLL  = 5'd5;
  localparam logic [4:0] C_OP_SRL  = 5'd6;
  localparam logic [4:0] C_OP_SRA  = 5'd7;
  localparam logic [4:0] C_OP_SLLV = 5'd8;
  localparam logic [4:0] C_OP_SRLV = 5'd9;
  localparam logic [4:0] C_OP_SRAV = 5'd10;
  localparam logic [4:0] C_OP_SYNC = 5'd11;
  localparam logic [4:0] C_OP_ANDI = 5'd12;
  localparam logic [4:0] C_OP_ORI  = 5'd13;
  localparam logic [4:0] C_OP_XORI = 5'd14;
  localparam logic [4:0] C_OP_LUI  = 5'd15;
  localparam logic [4:0] C_OP_PREF = 5'd16;

  logic [31:0]   word_mem_q [DEPTH];
  logic [31:0]   word_mem_d [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   pc_mem_d   [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [31:0]   next_pc_q, next_pc_d;
  logic          err_q, err_d;

  logic [31:0] enc_word;
  logic        accept;
  logic        push;
  logic        pop;

  // Undefined ops fall through to the all-zero word (NOP encoding).
  always_comb begin
    enc_word = 32'h0;
    case (op_i)
      C_OP_NOP:  enc_word = 32'h0;
      C_OP_AND:  enc_word = {6'h00, rs_i, rt_i, rd_i, 5'h00, 6'h24};
      C_OP_OR:   enc_word = {6'h00, rs_i, rt_i, rd_i, 5'h00, 6'h25};
      C_OP_XOR:  enc_word = {6'h00, rs_i, rt_i, rd_i, 5'h00, 6'h26};
      C_OP_NOR:  enc_word = {6'h00, rs_i, rt_i, rd_i, 5'h00, 6'h27};
      C_OP_SLL:  enc_word = {6'h00, 5'h00, rt_i, rd_i, sa_i, 6'h00};
      C_OP_SRL:  enc_word = {6'h00, 5'h00, rt_i, rd_i, sa_i, 6'h02};
      C_OP_SRA:  enc_word = {6'h00, 5'h00, rt_i, rd_i, sa_i, 6'h03};
      C_OP_SLLV: enc_word = {6'h00, rs_i, rt_i, rd_i, 5'h00, 6'h04};
      C_OP_SRLV: enc_word = {6'h00, rs_i, rt_i, rd_i, 5'h00, 6'h06};
      C_OP_SRAV: enc_word = {6'h00, rs_i, rt_i, rd_i, 5'h00, 6'h07};
      C_OP_SYNC: enc_word = {6'h00, 15'h0000, sa_i, 6'h0F};
      C_OP_ANDI: enc_word = {6'h0C, rs_i, rt_i, imm_i};
      C_OP_ORI:  enc_word = {6'h0D, rs_i, rt_i, imm_i};
      C_OP_XORI: enc_word = {6'h0E, rs_i, rt_i, imm_i};
      C_OP_LUI:  enc_word = {6'h0F, 5'h00, rt_i, imm_i};
      C_OP_PREF: enc_word = {6'h33, rs_i, rt_i, imm_i};
      default:   enc_word = 32'h0;
    endcase
  end

  assign in_ready_o  = (count_q < C_DEPTH);
  assign out_valid_o = (count_q != '0);
  assign accept      = in_valid_i & in_ready_o & ~flush_i;
  assign pop         = out_valid_o & out_ready_i & ~flush_i;

`ifdef INST_ENC_ILLEGAL_CHECK_EN
  logic illegal;
  assign illegal = (op_i > C_OP_PREF);
  assign push    = accept & ~illegal;
  assign err_d   = accept & illegal;
`else
  assign push    = accept;
  assign err_d   = 1'b0;
`endif

  always_comb begin
    word_mem_d = word_mem_q;
    pc_mem_d   = pc_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    next_pc_d  = next_pc_q;
    if (flush_i) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      next_pc_d = flush_pc_i;
    end else begin
      if (push) begin
        word_mem_d[wr_ptr_q] = enc_word;
        pc_mem_d[wr_ptr_q]   = next_pc_q;
        wr_ptr_d             = wr_ptr_q + 1'b1;
        next_pc_d            = next_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      next_pc_q <= PC_RESET;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      next_pc_q <= next_pc_d;
      err_q     <= err_d;
    end
  end

  // Storage needs no reset: the output mux hides stale entries.
  always_ff @(posedge clk) begin
    word_mem_q <= word_mem_d;
    pc_mem_q   <= pc_mem_d;
  end

  assign inst_o  = out_valid_o ? word_mem_q[rd_ptr_q] : 32'h0;
  assign pc_o    = out_valid_o ? pc_mem_q[rd_ptr_q]   : 32'h0;
  assign count_o = count_q;
  assign err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : tb_inst_encoder                                              |
// | Purpose  : directed + random stimulus against a queue-based model.      |
// | Revision : 1.0  initial release                                         |
// +-------------------------------------------------------------------------+
module tb_inst_encoder;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] PC_RESET = 32'h0;
  localparam int unsigned CW       = $clog2(DEPTH) + 1;
`ifdef INST_ENC_ILLEGAL_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [4:0]    op_i = '0, rs_i = '0, rt_i = '0, rd_i = '0, sa_i = '0;
  logic [15:0]   imm_i = '0;
  logic          flush_i = 1'b0;
  logic [31:0]   flush_pc_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [31:0]   inst_o, pc_o;
  logic [CW-1:0] count_o;
  logic          err_o;

  always #5 clk = ~clk;

  inst_encoder #(.DEPTH(DEPTH), .PC_RESET(PC_RESET)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .sa_i(sa_i), .imm_i(imm_i),
    .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .inst_o(inst_o), .pc_o(pc_o), .count_o(count_o), .err_o(err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q_word[$];
  logic [31:0] q_pc[$];
  logic [31:0] m_pc  = PC_RESET;
  bit          m_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Field placement by arithmetic: opcode<<26, rs<<21, rt<<16, rd<<11, sa<<6, low bits.
  function automatic logic [31:0] ref_enc(input logic [31:0] op, input logic [31:0] rs,
                                          input logic [31:0] rt, input logic [31:0] rd,
                                          input logic [31:0] sa, input logic [31:0] imm);
    logic [31:0] r;
    r = 32'h0;
    if (op >= 1 && op <= 4)        r = (rs << 21) + (rt << 16) + (rd << 11) + 32'h23 + op;
    else if (op >= 5 && op <= 7)   r = (rt << 16) + (rd << 11) + (sa << 6) + ((op == 5) ? 0 : op - 4);
    else if (op >= 8 && op <= 10)  r = (rs << 21) + (rt << 16) + (rd << 11) + ((op == 8) ? 4 : op - 3);
    else if (op == 11)             r = (sa << 6) + 15;
    else if (op >= 12 && op <= 14) r = (op << 26) + (rs << 21) + (rt << 16) + imm;
    else if (op == 15)             r = (32'd15 << 26) + (rt << 16) + imm;
    else if (op == 16)             r = (32'h33 << 26) + (rs << 21) + (rt << 16) + imm;
    return r;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, "_valid"}, 32'(out_valid_o), 32'(q_word.size() != 0));
    check({tag, "_inst"},  inst_o, (q_word.size() != 0) ? q_word[0] : 32'h0);
    check({tag, "_pc"},    pc_o,   (q_pc.size()   != 0) ? q_pc[0]   : 32'h0);
    check({tag, "_count"}, 32'(count_o), 32'(q_word.size()));
    check({tag, "_ready"}, 32'(in_ready_o), 32'(q_word.size() < DEPTH));
    check({tag, "_err"},   32'(err_o), 32'(m_err));
  endtask

  task automatic step(input bit v, input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sa, input logic [15:0] imm,
                      input bit fl, input logic [31:0] fpc, input bit rdy, input string tag);
    bit acc, pp, bad;
    @(negedge clk);
    in_valid_i = v; op_i = op; rs_i = rs; rt_i = rt; rd_i = rd; sa_i = sa; imm_i = imm;
    flush_i = fl; flush_pc_i = fpc; out_ready_i = rdy;
    @(posedge clk);
    if (rst || fl) begin
      q_word.delete(); q_pc.delete();
      m_pc  = rst ? PC_RESET : fpc;
      m_err = 1'b0;
    end else begin
      acc = v && (q_word.size() < DEPTH);
      pp  = rdy && (q_word.size() != 0);
      bad = (op > 16);
      if (pp) begin
        void'(q_word.pop_front());
        void'(q_pc.pop_front());
      end
      m_err = acc && bad && CHK_EN;
      if (acc && !(bad && CHK_EN)) begin
        q_word.push_back(ref_enc(32'(op), 32'(rs), 32'(rt), 32'(rd), 32'(sa), 32'(imm)));
        q_pc.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
    compare_all(tag);
  endtask

  task automatic push(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sa, input logic [15:0] imm,
                      input bit rdy);
    step(1'b1, op, rs, rt, rd, sa, imm, 1'b0, 32'h0, rdy, "push");
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0, 32'h0, rdy, "idle");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 1'b0, 32'h0, 1'b1, "rst");
    rst = 1'b0;
  endtask

  task automatic push_rand(input bit rdy);
    push(5'($urandom_range(0, 16)), 5'($urandom), 5'($urandom), 5'($urandom),
         5'($urandom), 16'($urandom), rdy);
  endtask

  initial begin
    // T1: single ORI word, one-cycle latency from an empty FIFO
    do_reset();
    push(5'd13, 5'd0, 5'd1, 5'd0, 5'd0, 16'h1100, 1'b0);
    check("t1_inst", inst_o, 32'h34011100);
    check("t1_pc", pc_o, 32'h0);
    check("t1_count", 32'(count_o), 32'd1);

    // T2: ordering and forced-zero fields
    do_reset();
    push(5'd1,  5'd1, 5'd2, 5'd3, 5'd0, 16'h0,    1'b0);
    push(5'd5,  5'd7, 5'd2, 5'd2, 5'd8, 16'h0,    1'b0);
    push(5'd15, 5'd5, 5'd1, 5'd0, 5'd0, 16'h0101, 1'b0);
    check("t2_w0", inst_o, 32'h00221824); check("t2_p0", pc_o, 32'h0);
    idle(1'b1);
    check("t2_w1", inst_o, 32'h00021200); check("t2_p1", pc_o, 32'h4);
    idle(1'b1);
    check("t2_w2", inst_o, 32'h3C010101); check("t2_p2", pc_o, 32'h8);
    idle(1'b1);
    check("t2_empty", 32'(out_valid_o), 32'd0);

    // T3: fill, push+pop while full, drain
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_rand(1'b0);
    check("t3_full_cnt", 32'(count_o), DEPTH);
    check("t3_full_rdy", 32'(in_ready_o), 32'd0);
    push_rand(1'b1);
    check("t3_pop_cnt", 32'(count_o), DEPTH - 1);
    check("t3_pop_rdy", 32'(in_ready_o), 32'd1);
    for (int i = 0; i < DEPTH; i++) idle(1'b1);

    // T4: flush beats a simultaneous push
    do_reset();
    for (int i = 0; i < 3; i++) push_rand(1'b0);
    step(1'b1, 5'd13, 5'd1, 5'd2, 5'd0, 5'd0, 16'hBEEF, 1'b1, 32'h100, 1'b1, "t4_flush");
    check("t4_cnt", 32'(count_o), 32'd0);
    push_rand(1'b0);
    check("t4_pc", pc_o, 32'h100);

    // T5: PC wraps past 2^32
    step(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b1, 32'hFFFFFFFC, 1'b0, "t5_flush");
    push_rand(1'b0);
    push_rand(1'b0);
    check("t5_pc0", pc_o, 32'hFFFFFFFC);
    idle(1'b1);
    check("t5_pc1", pc_o, 32'h0);

    // T6: undefined op
    do_reset();
    push(5'd20, 5'd3, 5'd4, 5'd5, 5'd6, 16'h1234, 1'b0);
`ifdef INST_ENC_ILLEGAL_CHECK_EN
    check("t6_err", 32'(err_o), 32'd1);
    check("t6_cnt", 32'(count_o), 32'd0);
    idle(1'b0);
    check("t6_err_clr", 32'(err_o), 32'd0);
    push(5'd13, 5'd0, 5'd1, 5'd0, 5'd0, 16'h1, 1'b0);
    check("t6_pc", pc_o, 32'h0);
`else
    check("t6_inst", inst_o, 32'h0);
    check("t6_cnt", 32'(count_o), 32'd1);
    check("t6_err", 32'(err_o), 32'd0);
    push(5'd13, 5'd0, 5'd1, 5'd0, 5'd0, 16'h1, 1'b1);
    check("t6_pc", pc_o, 32'h4);
`endif

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      step(($urandom_range(0, 3) != 0), 5'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), 5'($urandom), 16'($urandom), ($urandom_range(0, 31) == 0),
           $urandom, ($urandom_range(0, 2) != 0), "rnd");
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
